// File: rtl/pll_supervisor_if.sv
// pll_supervisor_if: PLL lock input and reset/status outputs of the supervisor.
// RCW must equal $clog2(MAX_RETRIES+1) of the attached supervisor.
interface pll_supervisor_if #(
  parameter int RCW = 3
);
  logic           locked_in;
  logic           pll_rst;
  logic           sys_rst;
  logic           ready;
  logic           fail;
  logic [RCW-1:0] retry_count;
  logic [7:0]     lock_loss_count;

  modport master (
    input  locked_in,
    output pll_rst, sys_rst, ready, fail,
    output retry_count, lock_loss_count
  );

  modport slave (
    output locked_in,
    input  pll_rst, sys_rst, ready, fail,
    input  retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_supervisor.sv
// pll_supervisor: PLL reset/lock watchdog and system reset sequencer.
// Option: define PLL_SUPERVISOR_RELOCK_EN to restart the PLL after lock loss.
module pll_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES       = 256,
  parameter int MAX_RETRIES         = 4
) (
  input logic              clk,
  input logic              rst,
  pll_supervisor_if.master sup
);

  localparam int M1 = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                      RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAXC = (M1 > STABLE_CYCLES) ? M1 : STABLE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int RCW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRIES);
  localparam logic [RCW-1:0] RETRY_ONE = RCW'(1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RCW-1:0] retry_q, retry_d;
  logic [RCW-1:0] retry_inc;
  logic [7:0]     loss_q, loss_d;
  logic           s1_q, s2_q;
  logic           locked_sync;
  logic           pll_rst_q, pll_rst_d;
  logic           sys_rst_q, sys_rst_d;
  logic           ready_q, ready_d;
  logic           fail_q, fail_d;

  assign locked_sync = s2_q;
  assign retry_inc   = retry_q + RETRY_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sup.locked_in;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // lock takes priority over a coincident timeout
        if (locked_sync) begin
          state_d = S_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STABILIZE: begin
        if (!locked_sync) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!locked_sync) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          cnt_d = '0;
`ifdef PLL_SUPERVISOR_RELOCK_EN
          state_d = S_RESET_PLL;
          retry_d = '0;
`else
          state_d = S_FAIL;
`endif
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
      end
    endcase
    // outputs follow the next state so they switch with the transition
    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign sup.pll_rst         = pll_rst_q;
  assign sup.sys_rst         = sys_rst_q;
  assign sup.ready           = ready_q;
  assign sup.fail            = fail_q;
  assign sup.retry_count     = retry_q;
  assign sup.lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: directed edge-numbered vectors for pll_supervisor.
// Expectations follow the PLL_SUPERVISOR_RELOCK_EN setting of the build.
module tb_pll_supervisor;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   edge_n;

  pll_supervisor_if #(.RCW(2)) bus ();

  pll_supervisor #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .STABLE_CYCLES      (8),
    .MAX_RETRIES        (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sup(bus.master)
  );

  typedef struct {
    int          e;
    logic        set;
    logic        lk;
    logic        chk;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] ex(logic p, logic s, logic r, logic f,
                                     logic [1:0] rc, logic [7:0] ll);
    return {p, s, r, f, rc, ll};
  endfunction

  function automatic logic [13:0] outs();
    return {bus.pll_rst, bus.sys_rst, bus.ready, bus.fail,
            bus.retry_count, bus.lock_loss_count};
  endfunction

  function automatic void add(int e, logic set, logic lk, logic c,
                              logic [13:0] x);
    vec_t v;
    v.e = e; v.set = set; v.lk = lk; v.chk = c; v.exp = x;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [13:0] act,
                     input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pll/sys/rdy/fail/rc/loss=%b_%b_%b_%b_%0d_%0d expected %b_%b_%b_%b_%0d_%0d",
               nm, act[13], act[12], act[11], act[10], act[9:8], act[7:0],
               exp[13], exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset(input logic lk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.locked_in = lk;
    #1;
    chk("async_reset", outs(), ex(1, 1, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      while (edge_n < tbl[i].e) tick();
      if (tbl[i].chk)
        chk($sformatf("%s@e%0d", tag, tbl[i].e), outs(), tbl[i].exp);
      if (tbl[i].set) bus.locked_in = tbl[i].lk;
    end
    tbl.delete();
  endtask

  task automatic load_a();
    add(3,  0, 0, 1, ex(1, 1, 0, 0, 0, 0));
    add(4,  0, 0, 1, ex(0, 1, 0, 0, 0, 0));
    add(12, 0, 0, 1, ex(0, 1, 0, 0, 0, 0));
    add(13, 0, 0, 1, ex(0, 0, 1, 0, 0, 0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    rst = 1'b1;
    bus.locked_in = 1'b1;
    #3;
    chk("reset_state", outs(), ex(1, 1, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // locked from the start, then lock loss in RUN
    load_a();
    add(100, 1, 0, 1, ex(0, 0, 1, 0, 0, 0));
    add(102, 0, 0, 1, ex(0, 0, 1, 0, 0, 0));
`ifdef PLL_SUPERVISOR_RELOCK_EN
    add(103, 1, 1, 1, ex(1, 1, 0, 0, 0, 1));
    add(106, 0, 0, 1, ex(1, 1, 0, 0, 0, 1));
    add(107, 0, 0, 1, ex(0, 1, 0, 0, 0, 1));
    add(115, 0, 0, 1, ex(0, 1, 0, 0, 0, 1));
    add(116, 0, 0, 1, ex(0, 0, 1, 0, 0, 1));
`else
    add(103, 1, 1, 1, ex(1, 1, 0, 1, 0, 1));
    add(150, 0, 0, 1, ex(1, 1, 0, 1, 0, 1));
`endif
    run_tbl("lock_run");

    // never locks: two timeouts then terminal FAIL
    do_reset(1'b0);
    add(4,   0, 0, 1, ex(0, 1, 0, 0, 0, 0));
    add(35,  0, 0, 1, ex(0, 1, 0, 0, 0, 0));
    add(36,  0, 0, 1, ex(1, 1, 0, 0, 1, 0));
    add(39,  0, 0, 1, ex(1, 1, 0, 0, 1, 0));
    add(40,  0, 0, 1, ex(0, 1, 0, 0, 1, 0));
    add(71,  0, 0, 1, ex(0, 1, 0, 0, 1, 0));
    add(72,  0, 0, 1, ex(1, 1, 0, 1, 2, 0));
    add(200, 0, 0, 1, ex(1, 1, 0, 1, 2, 0));
    run_tbl("timeout");

    // one-cycle drop during STABILIZE
    do_reset(1'b1);
    add(6,  1, 0, 1, ex(0, 1, 0, 0, 0, 0));
    add(7,  1, 1, 1, ex(0, 1, 0, 0, 0, 0));
    add(8,  0, 0, 1, ex(0, 1, 0, 0, 0, 0));
    add(9,  0, 0, 1, ex(1, 1, 0, 0, 1, 0));
    add(12, 0, 0, 1, ex(1, 1, 0, 0, 1, 0));
    add(13, 0, 0, 1, ex(0, 1, 0, 0, 1, 0));
    add(21, 0, 0, 1, ex(0, 1, 0, 0, 1, 0));
    add(22, 0, 0, 1, ex(0, 0, 1, 0, 0, 0));
    run_tbl("drop");

    // async reset while in STABILIZE, then the sequence repeats
    do_reset(1'b1);
    while (edge_n < 7) tick();
    do_reset(1'b1);
    load_a();
    run_tbl("rst_stab");

`ifdef PLL_SUPERVISOR_RELOCK_EN
    // lock-loss counter saturation
    for (int i = 0; i < 300; i++) begin
      int n;
      bus.locked_in = 1'b0;
      n = 0;
      while (bus.ready && n < 50) begin tick(); n++; end
      bus.locked_in = 1'b1;
      while (!bus.ready && n < 100) begin tick(); n++; end
      if (n >= 50 && !bus.ready || bus.ready && n >= 100) begin
        checks++;
        errors++;
        $display("FAIL relock_wait: event %0d ready=%b after %0d cycles",
                 i, bus.ready, n);
        break;
      end
      if (i == 254)
        chk("loss_255", outs(), ex(0, 0, 1, 0, 0, 255));
    end
    chk("loss_sat", outs(), ex(0, 0, 1, 0, 0, 255));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
